// File: rtl/ram_16k.sv
// 16K x 16-bit data memory: four 4K banks, each a 3-bit-per-level tree of 8-word register blocks.
// Combinational read, synchronous write on load, asynchronous clear on reset_n low.
module ram_16k (
    input  logic        clk,
    input  logic        load,
    input  logic [13:0] address,
    input  logic [15:0] in,
    output logic [15:0] out,
    input  logic        reset_n
);

    // Indices follow the block hierarchy: bank -> 512 -> 64 -> 8 -> word.
    logic [1:0]  bank_sel;
    logic [2:0]  blk512_sel;
    logic [2:0]  blk64_sel;
    logic [2:0]  blk8_sel;
    logic [2:0]  word_sel;

    logic [15:0] mem_q [4][8][8][8][8];
    logic [15:0] wdata_d;

    always_comb begin
        bank_sel   = address[13:12];
        blk512_sel = address[11:9];
        blk64_sel  = address[8:6];
        blk8_sel   = address[5:3];
        word_sel   = address[2:0];
        wdata_d    = in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned b = 0; b < 4; b++)
                for (int unsigned i = 0; i < 8; i++)
                    for (int unsigned j = 0; j < 8; j++)
                        for (int unsigned k = 0; k < 8; k++)
                            for (int unsigned w = 0; w < 8; w++)
                                mem_q[b][i][j][k][w] <= '0;
        end else if (load) begin
            mem_q[bank_sel][blk512_sel][blk64_sel][blk8_sel][word_sel] <= wdata_d;
        end
    end

    always_comb begin
        out = mem_q[bank_sel][blk512_sel][blk64_sel][blk8_sel][word_sel];
    end

endmodule

// File: tb/tb_ram_16k.sv
// Scoreboard bench for ram_16k: expected words come from a bench-side memory model,
// pushed when a read is set up and popped when the combinational output is sampled.
module tb_ram_16k;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load;
    logic [13:0] address;
    logic [15:0] din;
    logic [15:0] dout;

    int errors = 0;
    int checks = 0;

    logic [15:0] model [16384];
    logic [15:0] exp_q [$];

    always #5 clk = ~clk;

    ram_16k dut (
        .clk     (clk),
        .load    (load),
        .address (address),
        .in      (din),
        .out     (dout),
        .reset_n (reset_n)
    );

    task automatic model_clear();
        for (int i = 0; i < 16384; i++) model[i] = 16'h0000;
    endtask

    task automatic do_write(input logic [13:0] a, input logic [15:0] d);
        @(negedge clk);
        address = a;
        din     = d;
        load    = 1'b1;
        @(posedge clk);
        model[a] = d;
        #1;
        load = 1'b0;
    endtask

    task automatic test_reset();
        logic [13:0] addrs [4];
        logic [15:0] e;
        addrs = '{14'h0000, 14'h0FFF, 14'h1000, 14'h3FFF};
        @(negedge clk);
        reset_n = 1'b0;
        model_clear();
        #2;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            address = addrs[i];
            exp_q.push_back(model[addrs[i]]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++;
                $display("FAIL reset_read addr=%h got=%h want=%h", addrs[i], dout, e);
            end
        end
    endtask

    task automatic test_basic();
        logic [15:0] e;
        do_write(14'h0000, 16'hFFFF);
        exp_q.push_back(model[14'h0000]);
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL basic_write got=%h want=%h", dout, e);
        end
        @(negedge clk);
        address = 14'h0000;
        din     = 16'h1234;
        load    = 1'b0;
        exp_q.push_back(model[14'h0000]);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL basic_noload got=%h want=%h", dout, e);
        end
    endtask

    task automatic test_bank_isolation();
        logic [13:0] addrs [5];
        logic [15:0] e;
        addrs = '{14'h0005, 14'h1005, 14'h2005, 14'h3005, 14'h0006};
        do_write(14'h0005, 16'h1111);
        do_write(14'h1005, 16'h2222);
        do_write(14'h2005, 16'h3333);
        do_write(14'h3005, 16'h4444);
        @(negedge clk);
        for (int i = 0; i < 5; i++) exp_q.push_back(model[addrs[i]]);
        for (int i = 0; i < 5; i++) begin
            address = addrs[i];
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++;
                $display("FAIL bank_iso addr=%h got=%h want=%h", addrs[i], dout, e);
            end
        end
    endtask

    task automatic test_boundary();
        logic [13:0] addrs [4];
        logic [15:0] e;
        addrs = '{14'h3FFF, 14'h0000, 14'h3FFE, 14'h0001};
        do_write(14'h3FFF, 16'hA5A5);
        do_write(14'h0000, 16'h5A5A);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            address = addrs[i];
            exp_q.push_back(model[addrs[i]]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++;
                $display("FAIL boundary addr=%h got=%h want=%h", addrs[i], dout, e);
            end
        end
    endtask

    task automatic test_pre_edge();
        logic [15:0] e;
        @(negedge clk);
        address = 14'h0010;
        din     = 16'hBEEF;
        load    = 1'b1;
        exp_q.push_back(model[14'h0010]);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL pre_edge_old got=%h want=%h", dout, e);
        end
        @(posedge clk);
        model[14'h0010] = 16'hBEEF;
        exp_q.push_back(model[14'h0010]);
        #1;
        load = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL pre_edge_new got=%h want=%h", dout, e);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [13:0] addrs [8];
        logic [15:0] e;
        addrs = '{14'h3FFF, 14'h0000, 14'h0005, 14'h1005,
                  14'h2005, 14'h3005, 14'h0010, 14'h0006};
        @(negedge clk);
        address = 14'h3FFF;
        #2;
        reset_n = 1'b0;
        model_clear();
        exp_q.push_back(model[14'h3FFF]);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (dout !== e) begin
            errors++;
            $display("FAIL reset_mid_immediate got=%h want=%h", dout, e);
        end
        // A write attempted while reset is held must be ignored.
        load = 1'b1;
        din  = 16'hDEAD;
        @(posedge clk);
        #1;
        load = 1'b0;
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            address = addrs[i];
            exp_q.push_back(model[addrs[i]]);
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++;
                $display("FAIL reset_mid_clear addr=%h got=%h want=%h", addrs[i], dout, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] a;
        logic [15:0] e;
        logic [13:0] used [6];
        for (int i = 0; i < 6; i++) begin
            a = 14'($urandom_range(16383, 0));
            used[i] = a;
            do_write(a, 16'($urandom));
        end
        @(negedge clk);
        for (int i = 0; i < 6; i++) exp_q.push_back(model[used[i]]);
        for (int i = 0; i < 6; i++) begin
            address = used[i];
            #1;
            e = exp_q.pop_front();
            checks++;
            if (dout !== e) begin
                errors++;
                $display("FAIL back_to_back addr=%h got=%h want=%h", used[i], dout, e);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        address = '0;
        din     = '0;
        model_clear();
        test_reset();
        test_basic();
        test_bank_isolation();
        test_boundary();
        test_pre_edge();
        test_reset_mid_run();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
